uart_echo_dut: RTL and testbench
================================

Name: uart_echo_dut

Overview:
- Single-channel UART echo repeater, 8N1 framing, LSB first.
- Receives serial bytes on `in`, buffers one byte, retransmits it unchanged on `out` at the same bit rate.
- Used as the serial test target on the tile: one serial input pin, one serial output pin, idle-high lines.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit, for both RX and TX. Legal range ≥4. Bit-timing counters are sized by clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  1  UART RX line, asynchronous to clk, idle high.
- out  output  1  UART TX line, registered, idle high.

Behaviour:
Reset:
- rst_n low clears all state asynchronously and immediately.
- out=1; RX and TX FSMs go to IDLE; holding register is empty (full=0); synchronizer flops are set to 1.
- Reset asserted mid-frame aborts RX and TX; no partial frame resumes after release.

Input path:
- Two-flop synchronizer on `in`; rx_s = second flop. All RX decisions use rx_s.

RX FSM (IDLE, START, DATA, STOP, WAIT_IDLE):
- IDLE: rx_s==0 -> START, bit counter cleared.
- START: after CLKS_PER_BIT/2 cycles (integer division), re-sample rx_s.
  - rx_s==0 -> DATA.
  - rx_s==1 -> glitch; return to IDLE with nothing captured.
- DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit); shift in 8 bits, first bit -> bit0.
- STOP: sample CLKS_PER_BIT cycles after the last data sample.
  - rx_s==1 -> byte valid -> IDLE.
  - rx_s==0 -> framing error; byte discarded -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then IDLE.

Holding register:
- One byte plus a full flag.
- A valid stop-bit sample edge S writes the byte and sets full, if full==0.
- If full==1 at S: the new byte is dropped (overrun); the stored byte is kept.
- If TX loads on the same edge S: the load clears full and the new byte is written, so full stays 1 with the new byte.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: when full==1, load the shift register, clear full, drive out=0 on that same edge.
  - A byte written at edge S is therefore started at edge S+1.
- START: out=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
- STOP: out=1 for CLKS_PER_BIT cycles, then IDLE.
- A pending byte may start on the edge the stop period ends, with no extra idle gap.

Timing and throughput:
- Echoed byte == received byte; no transformation.
- Continuous back-to-back RX frames at the same rate never overrun: TX empties the holding register on load, one cycle after write.
- out is driven only by the TX FSM. It is high in IDLE and STOP, and never glitches between bits.

Test Plan:
- Reset check: rst_n=0 with in=1 -> out=1 immediately. Release rst_n, hold in=1 for 20 bit times -> out stays 1.
- Echo 0xA5 (CLKS_PER_BIT=16) -> out frame is 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles; out falls at stop-sample edge +1.
- Glitch: in=0 for 4 cycles, then high -> no frame on out; a following valid 0x3C is echoed correctly.
- Framing error: 0x3C with stop bit 0, line held low 2 bit times, then high -> no output. A subsequent valid 0x55 -> out echoes 0x55.
- Back-to-back 0x00 then 0xFF with no idle gap -> out emits both, in order, both bit-exact, with no overrun.
- Reset mid-TX: assert rst_n=0 during data bit 3 of an echo -> out=1 asynchronously; after release no further bits are sent; the next valid byte echoes normally.

Source files
------------

// File: rtl/uart_echo_dut.sv
// UART 8N1 echo repeater: receives one byte on `in`, holds it in a single-entry
// buffer and retransmits it unchanged on `out` at the same bit rate.
module uart_echo_dut #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    //  rx state  | meaning
    //  RX_IDLE   | line idle, waiting for a falling edge on rx_s
    //  RX_START  | half-bit wait, then confirm start bit is still low
    //  RX_DATA   | sampling 8 data bits mid-bit, LSB first
    //  RX_STOP   | sampling stop bit; high = byte valid, low = framing error
    //  RX_WAIT   | framing error, wait for the line to return high
    //
    //  tx state  | meaning
    //  TX_IDLE   | out high, waiting for a full holding register
    //  TX_START  | out low for one bit time
    //  TX_DATA   | shifting out 8 data bits, LSB first
    //  TX_STOP   | out high for one bit time; may chain straight into a new load

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    logic            sync1_q, rx_s_q;

    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid;

    logic [7:0]      hold_q, hold_d;
    logic            full_q, full_d;

    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            out_q, out_d;
    logic            tx_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= in;
            rx_s_q  <= sync1_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_TC;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (!rx_s_q) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = FULL_TC;
                        rx_bit_d   = 3'd0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                    rx_cnt_d   = FULL_TC;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    if (rx_s_q) begin
                        rx_valid   = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_WAIT: begin
                if (rx_s_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A TX load on the write edge frees the slot, so the new byte still lands.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (tx_load) begin
            full_d = 1'b0;
        end
        if (rx_valid && (!full_q || tx_load)) begin
            hold_d = rx_shift_q;
            full_d = 1'b1;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        out_d      = out_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                out_d = 1'b1;
                if (full_q) begin
                    tx_load = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    out_d      = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = FULL_TC;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = FULL_TC;
                    if (tx_bit_q == 3'd7) begin
                        out_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        out_d      = tx_shift_q[1];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    if (full_q) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_shift_d = hold_q;
            out_d      = 1'b0;
            tx_state_d = TX_START;
            tx_cnt_d   = FULL_TC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            hold_q     <= 8'h00;
            full_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            out_q      <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            out_q      <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_uart_echo_dut.sv
// Directed bench for uart_echo_dut: drives 8N1 frames on `in` and checks the
// echoed frames on `out` cycle by cycle.
module tb_uart_echo_dut;

    localparam int CPB = 16;
    // Start bit driven just after posedge n appears on out just after posedge n+156:
    // 2 sync + 1 detect + 8 half bit + 8*16 data + 16 stop + 1 load.
    localparam int ECHO_LAT = 156;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in = 1'b1;
    logic out;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    uart_echo_dut #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send_bits(input logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            in = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_silent(input string tag, input int cycles);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (out !== 1'b1) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_err++;
            $error("FAIL %s: observed out low at least once, expected out=1 for %0d cycles", tag, cycles);
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] data, input int exp_start);
        logic [9:0] bits;
        logic       ok;
        logic       bad;
        int         n;
        bits = {1'b1, data, 1'b0};
        n = 0;
        while (out !== 1'b0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        assert (n < 400) else begin
            n_err++;
            $error("FAIL %s_timeout: observed no start bit, expected start within 400 cycles", tag);
        end
        if (n < 400) begin
            if (exp_start >= 0) begin
                n_cmp++;
                assert (cyc === exp_start) else begin
                    n_err++;
                    $error("FAIL %s_start: observed cycle %0d, expected cycle %0d", tag, cyc, exp_start);
                end
            end
            for (int b = 0; b < 10; b++) begin
                ok = 1'b1;
                bad = bits[b];
                for (int k = 0; k < CPB; k++) begin
                    if (out !== bits[b]) begin
                        ok = 1'b0;
                        bad = out;
                    end
                    @(posedge clk);
                    #1;
                end
                n_cmp++;
                assert (ok === 1'b1) else begin
                    n_err++;
                    $error("FAIL %s_bit%0d: observed %b within bit, expected %b for all %0d cycles",
                           tag, b, bad, bits[b], CPB);
                end
            end
        end
    endtask

    initial begin
        int n;

        // Reset asserted with in idle: out high immediately, before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        assert (out === 1'b1) else begin
            n_err++;
            $error("FAIL reset_out: observed %b, expected 1", out);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_silent("reset_idle", 20 * CPB);

        // Echo 0xA5 with exact latency.
        n = cyc;
        fork
            send_bits({1'b1, 8'hA5, 1'b0});
            check_frame("echo_a5", 8'hA5, n + ECHO_LAT);
        join

        // Start-bit glitch shorter than half a bit: nothing echoed.
        in = 1'b0;
        repeat (4) @(posedge clk);
        #1 in = 1'b1;
        check_silent("glitch", 200);
        n = cyc;
        fork
            send_bits({1'b1, 8'h3C, 1'b0});
            check_frame("after_glitch_3c", 8'h3C, n + ECHO_LAT);
        join

        // Framing error: stop bit low, line held low two more bit times.
        fork
            begin
                send_bits({1'b0, 8'h3C, 1'b0});
                repeat (2 * CPB) @(posedge clk);
                #1 in = 1'b1;
            end
            check_silent("framing_err", 400);
        join
        n = cyc;
        fork
            send_bits({1'b1, 8'h55, 1'b0});
            check_frame("after_ferr_55", 8'h55, n + ECHO_LAT);
        join

        // Back-to-back frames with no idle gap.
        n = cyc;
        fork
            begin
                send_bits({1'b1, 8'h00, 1'b0});
                send_bits({1'b1, 8'hFF, 1'b0});
            end
            begin
                check_frame("b2b_00", 8'h00, n + ECHO_LAT);
                check_frame("b2b_ff", 8'hFF, n + 10 * CPB + ECHO_LAT);
            end
        join
        check_silent("b2b_tail", 100);

        // Reset during data bit 3 of echoed 0x96 (bit3 = 0).
        n = cyc;
        fork
            send_bits({1'b1, 8'h96, 1'b0});
            begin
                while (cyc < n + ECHO_LAT + 4 * CPB + 8) @(posedge clk);
                #1;
                n_cmp++;
                assert (out === 1'b0) else begin
                    n_err++;
                    $error("FAIL midtx_bit3: observed %b, expected 0", out);
                end
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                n_cmp++;
                assert (out === 1'b1) else begin
                    n_err++;
                    $error("FAIL midtx_reset_out: observed %b, expected 1", out);
                end
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        check_silent("midtx_after_release", 20 * CPB);
        n = cyc;
        fork
            send_bits({1'b1, 8'h81, 1'b0});
            check_frame("after_midtx_81", 8'h81, n + ECHO_LAT);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
